aether_cmd_driver: RTL

AETHER_CMD_DRIVER -- requirements
Module: aether_cmd_driver

---
 rtl/aether_cmd_pkg.sv | 26 ++
 rtl/aether_cmd_driver_rise_detect.sv | 21 ++
 rtl/aether_cmd_driver.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/aether_cmd_pkg.sv
// Shared types and constants for the Aether accelerator command driver.
package aether_cmd_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWaitIrq,
        StReadWait,
        StResp
    } state_e;

    typedef struct packed {
        logic [3:0]  instr;
        logic [3:0]  param_1;
        logic [15:0] param_2;
    } cmd_t;

    localparam logic [3:0] InstrNop      = 4'h0;
    localparam logic [3:0] InstrWriteReg = 4'h1;
    localparam logic [3:0] InstrReadReg  = 4'h2;
    localparam logic [3:0] InstrStart    = 4'h3;
    localparam logic [3:0] InstrLoad     = 4'h4;
    localparam logic [3:0] InstrStore    = 4'h5;
    localparam logic [3:0] InstrReset    = 4'hF;

endpackage

// File: rtl/aether_cmd_driver_rise_detect.sv
// Rising-edge detector: pulses for one cycle when sig_i goes from low to high.
module aether_rise_detect (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic sig_i,
    output logic rise_o
);

    logic prev_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= sig_i;
        end
    end

    assign rise_o = sig_i & ~prev_q;

endmodule

// File: rtl/aether_cmd_driver.sv
// Issues one host command to the accelerator, optionally waits for its interrupt
// and/or samples its data output, and returns exactly one response per request.
module aether_cmd_driver
    import aether_cmd_pkg::*;
#(
    parameter int unsigned ReadLatency   = 2,
    parameter int unsigned TimeoutCycles = 1_048_575,
    parameter logic [23:0] NopCmd        = 24'h000000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [23:0] req_cmd_i,
    input  logic        req_wait_irq_i,
    input  logic        req_read_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [15:0] rsp_data_o,
    output logic        rsp_timeout_o,
    output logic [23:0] cmd_o,
    input  logic [15:0] data_i,
    input  logic        interrupt_i,
    output logic        busy_o
);

    // One counter serves both the interrupt timeout and the read latency.
    localparam int unsigned CntMax = (TimeoutCycles > ReadLatency) ? TimeoutCycles : ReadLatency;
    localparam int unsigned CntW   = $clog2(CntMax + 1);

    state_e          state_q, state_d;
    cmd_t            cmd_q, cmd_d;
    logic            wait_q, wait_d;
    logic            read_q, read_d;
    logic            ready_q;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            irq_seen_q, irq_seen_d;
    logic [15:0]     data_q, data_d;
    logic            timeout_q, timeout_d;
    logic            irq_rise;
    logic            irq_hit;

    aether_rise_detect u_rise_detect (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .sig_i  (interrupt_i),
        .rise_o (irq_rise)
    );

    // An edge landing in the expiry cycle still counts as seen.
    assign irq_hit = irq_seen_q | irq_rise;

    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_t'(NopCmd);
        wait_d     = wait_q;
        read_d     = read_q;
        cnt_d      = cnt_q;
        irq_seen_d = irq_seen_q;
        data_d     = data_q;
        timeout_d  = timeout_q;

        if (irq_rise && (state_q == StIssue || state_q == StWaitIrq || state_q == StReadWait)) begin
            irq_seen_d = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (req_valid_i && ready_q) begin
                    cmd_d      = cmd_t'(req_cmd_i);
                    wait_d     = req_wait_irq_i;
                    read_d     = req_read_i;
                    irq_seen_d = 1'b0;
                    data_d     = 16'h0;
                    timeout_d  = 1'b0;
                    cnt_d      = '0;
                    state_d    = StIssue;
                end
            end
            StIssue: begin
                cnt_d = '0;
                if (wait_q) begin
                    state_d = StWaitIrq;
                end else if (read_q) begin
                    state_d = StReadWait;
                end else begin
                    state_d = StResp;
                end
            end
            StWaitIrq: begin
                if (irq_hit) begin
                    cnt_d   = '0;
                    state_d = read_q ? StReadWait : StResp;
                end else if (cnt_q == CntW'(TimeoutCycles - 1)) begin
                    cnt_d     = '0;
                    timeout_d = 1'b1;
                    data_d    = 16'h0;
                    state_d   = StResp;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StReadWait: begin
                if (cnt_q == CntW'(ReadLatency - 1)) begin
                    cnt_d   = '0;
                    data_d  = data_i;
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StResp: begin
                if (rsp_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            cmd_q      <= cmd_t'(NopCmd);
            wait_q     <= 1'b0;
            read_q     <= 1'b0;
            ready_q    <= 1'b0;
            cnt_q      <= '0;
            irq_seen_q <= 1'b0;
            data_q     <= 16'h0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            wait_q     <= wait_d;
            read_q     <= read_d;
            ready_q    <= (state_d == StIdle);
            cnt_q      <= cnt_d;
            irq_seen_q <= irq_seen_d;
            data_q     <= data_d;
            timeout_q  <= timeout_d;
        end
    end

    assign req_ready_o   = ready_q;
    assign cmd_o         = cmd_q;
    assign rsp_valid_o   = (state_q == StResp);
    assign rsp_data_o    = data_q;
    assign rsp_timeout_o = timeout_q;
    assign busy_o        = (state_q != StIdle);

endmodule
